// File: rtl/exec_unit_if.sv
// Execute-stage port bundle: issue side (operands + handshake) and register-file write port.
interface exec_unit_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       alu_op;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [WIDTH-1:0] imm;
  logic             alusrc;
  logic [AW-1:0]    dest;
  logic             regwrite_in;
  logic             regwrite;
  logic [AW-1:0]    wa;
  logic [WIDTH-1:0] wd;
  logic             zero;
  logic             busy;

  modport master (
    output in_valid, alu_op, rd1, rd2, imm, alusrc, dest, regwrite_in,
    input  in_ready, regwrite, wa, wd, zero, busy
  );

  modport slave (
    input  in_valid, alu_op, rd1, rd2, imm, alusrc, dest, regwrite_in,
    output in_ready, regwrite, wa, wd, zero, busy
  );
endinterface

// File: rtl/exec_unit.sv
// Execute stage: registered single-cycle ALU plus an 8-iteration shift-add multiplier
// that stalls issue (in_ready low) while it runs.
module exec_unit #(
  parameter int WIDTH = 8,
  parameter int AW    = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  exec_unit_if.slave  bus
);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                         OP_XOR = 4'd4, OP_NOR = 4'd5, OP_SLT = 4'd6, OP_SLL = 4'd7,
                         OP_SRL = 4'd8, OP_MUL = 4'd9;

  logic [0:0]       state;
  logic [WIDTH-1:0] b_sel, result;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic [2:0]       cnt;
  logic [AW-1:0]    dest_q;
  logic             we_q;
  logic             accept;
  logic             slt;

  assign bus.in_ready = (state == S_IDLE);
  assign bus.busy     = (state == S_MUL);
  assign accept       = bus.in_valid & bus.in_ready;
  assign b_sel        = bus.alusrc ? bus.imm : bus.rd2;
  assign slt          = $signed(bus.rd1) < $signed(b_sel);
  assign acc_nxt      = mplier[0] ? acc + mcand : acc;

  always_comb begin
    result = '0;
    case (bus.alu_op)
      OP_ADD:  result = bus.rd1 + b_sel;
      OP_SUB:  result = bus.rd1 - b_sel;
      OP_AND:  result = bus.rd1 & b_sel;
      OP_OR:   result = bus.rd1 | b_sel;
      OP_XOR:  result = bus.rd1 ^ b_sel;
      OP_NOR:  result = ~(bus.rd1 | b_sel);
      OP_SLT:  result[0] = slt;
      OP_SLL:  result = bus.rd1 << b_sel[2:0];
      OP_SRL:  result = bus.rd1 >> b_sel[2:0];
      default: result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      bus.regwrite <= 1'b0;
      bus.wa       <= '0;
      bus.wd       <= '0;
      bus.zero     <= 1'b0;
      mcand        <= '0;
      mplier       <= '0;
      acc          <= '0;
      cnt          <= '0;
      dest_q       <= '0;
      we_q         <= 1'b0;
    end else begin
      bus.regwrite <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          if (bus.alu_op == OP_MUL) begin
            mcand  <= bus.rd1;
            mplier <= b_sel;
            acc    <= '0;
            cnt    <= '0;
            dest_q <= bus.dest;
            we_q   <= bus.regwrite_in & (bus.dest != '0);
            state  <= S_MUL;
          end else begin
            bus.wd       <= result;
            bus.wa       <= bus.dest;
            bus.zero     <= (result == '0);
            bus.regwrite <= bus.regwrite_in & (bus.dest != '0);
          end
        end
        S_MUL: begin
          acc    <= acc_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 3'd1;
          // 8th iteration: acc_nxt is the finished product
          if (cnt == 3'd7) begin
            state        <= S_IDLE;
            bus.wd       <= acc_nxt;
            bus.wa       <= dest_q;
            bus.zero     <= (acc_nxt == '0);
            bus.regwrite <= we_q;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/exec_unit.md
# exec_unit

Execute stage of the 8-bit MIPS datapath. It sits directly downstream of the register file and consumes its registered read ports `rd1`/`rd2`. It computes a registered ALU result, with an iterative 8-cycle shift-add multiplier for MUL, and drives the register file's write port (`regwrite`, `wa`, `wd`). A valid/ready handshake stalls the issue logic while a multiply is in flight.

## Interface
- `WIDTH`, default 8: data width; must match the register file data width.
- `AW`, default 5: register address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operation presented this cycle; operands aligned with `rd1`/`rd2`.
- `in_ready`  out  1  unit can accept; an operation is accepted on an edge where `in_valid & in_ready`.
- `alu_op`  in  4  operation code (see Operation).
- `rd1`  in  WIDTH  operand A, driven by the register file.
- `rd2`  in  WIDTH  register operand B.
- `imm`  in  WIDTH  immediate operand.
- `alusrc`  in  1  1: B = `imm`; 0: B = `rd2`.
- `dest`  in  AW  destination register.
- `regwrite_in`  in  1  the instruction writes back.
- `regwrite`  out  1  one-cycle write strobe to the register file.
- `wa`  out  AW  write address.
- `wd`  out  WIDTH  write data.
- `zero`  out  1  registered flag: last produced result == 0.
- `busy`  out  1  multiply in progress.

## Operation
- Opcodes, with A = `rd1` and B = the selected operand:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR.
  - 6 SLT: signed compare; result is 1 or 0.
  - 7 SLL: A << B[2:0].
  - 8 SRL: A >> B[2:0], logical.
  - 9 MUL: low WIDTH bits of A*B.
  - 10–15: result 0, otherwise handled like a single-cycle op.
- Arithmetic is modulo 2^WIDTH; no overflow detection or trap.
- States: IDLE and MUL. `in_ready` = (state == IDLE); `busy` = (state == MUL). Both are combinational from state only.
- IDLE, accept of a non-MUL op:
  - Register `wd` = result, `wa` = `dest`, `zero` = (result == 0).
  - `regwrite` = `regwrite_in & (dest != 0)`.
  - Stay in IDLE.
- IDLE, accept of MUL:
  - Load mcand = A, mplier = B, acc = 0, cnt = 0.
  - Latch `dest` and the write-enable.
  - Go to MUL. `regwrite` = 0 this edge.
- MUL, each edge:
  - If mplier[0], then acc += mcand.
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - On the edge where cnt == 7 (the 8th iteration), go to IDLE. On that edge, register `wd` = final acc, `wa` = latched dest, `zero`, and `regwrite` = latched enable.
- `in_valid` while busy is not accepted; upstream holds the op and operands until `in_ready`.
- `regwrite` is a single-cycle pulse per produced result. `wd`, `wa` and `zero` hold their value until the next produced result.
- Accepting with `regwrite_in = 0`: result, `wa` and `zero` still update; `regwrite` stays 0.

## Timing
- Reset (`reset_n` low, asynchronous): state IDLE, `regwrite` 0, `wa` 0, `wd` 0, `zero` 0, `busy` 0, `in_ready` 1, internal accumulators 0.
- Reset mid-MUL aborts the multiply; no write occurs. The first accept is possible on the first edge after `reset_n` rises.
- Single-cycle op accepted at edge E: result and `regwrite` are visible in the cycle after E. Latency 1, throughput 1 per cycle.
- MUL accepted at edge E:
  - `in_ready` is low in cycles E+1 through E+8.
  - Result and `regwrite` are visible after edge E+8. Latency 8.
  - The next accept is possible at edge E+9 at the earliest (state is IDLE after E+8).
- Back-to-back single-cycle ops produce a `regwrite` pulse every cycle, each with its own `wa`/`wd`.
- Operands are sampled only on the accepting edge. Later changes to `rd1`/`rd2`/`imm` do not affect an in-flight MUL.

## Test plan
- **Reset:** assert `reset_n` = 0 mid-run → all outputs 0, `in_ready` = 1, asynchronously, without waiting for a clock edge.
- **ADD/SUB wrap:**
  - ADD A = 0xF0, B = 0x20, `dest` = 3 → next cycle `wd` = 0x10, `wa` = 3, `regwrite` = 1 for one cycle, `zero` = 0.
  - SUB 0x05 − 0x05 → `wd` = 0x00, `zero` = 1.
- **SLT signed / shifts / imm:**
  - SLT A = 0x80, B = 0x01 → `wd` = 1.
  - SLL A = 0x81, `imm` = 0x09 with `alusrc` = 1 → `wd` = 0x02 (shift by 1).
- **MUL:**
  - A = 13, B = 11, `dest` = 5 → `in_ready` low for exactly 8 cycles; then `wd` = 0x8F, `wa` = 5, single `regwrite` pulse.
  - A = 0x10, B = 0x10 → `wd` = 0x00, `zero` = 1.
  - Hold `in_valid` with an ADD during the MUL → the ADD is accepted only at E+9, and its result follows the MUL result.
- **Writes to $0:** ADD with `dest` = 0 and `regwrite_in` = 1 → `wd` updated, `regwrite` stays 0.
- **Reset mid-MUL:** pulse `reset_n` low at cycle E+4 → no `regwrite` ever; `busy` = 0; a new ADD accepted after release produces its result normally.
